// File: rtl/fib_counter.sv
// Free-running Fibonacci counter: out steps 0, 1, 2, 3, 5, 8, ...
// Additions wrap modulo 2^WIDTH and counting never stops.
module fib_counter #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;

  // One adder feeds both the output and the newer term.
  assign sum = a + b;

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
      a   <= '0;
      b   <= WIDTH'(1);
    end else begin
      out <= sum;
      a   <= b;
      b   <= sum;
    end
  end

endmodule

// File: tb/tb_fib_counter.sv
// Bench for fib_counter: directed boundaries plus random reset/run
// bursts, with 32-bit and 8-bit instances checked against F(k+1).
module tb_fib_counter;

  logic        clk;
  logic        rst;
  logic [31:0] out32;
  logic [7:0]  out8;

  int checks;
  int failures;
  int k;

  fib_counter #(.WIDTH(32)) dut32 (
    .out(out32),
    .clk(clk),
    .rst(rst)
  );

  fib_counter #(.WIDTH(8)) dut8 (
    .out(out8),
    .clk(clk),
    .rst(rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected out after k enabled edges since reset: 0, or F(k+1) mod 2^w.
  function automatic longint unsigned fib_out(int n, int w);
    longint unsigned x;
    longint unsigned y;
    longint unsigned t;
    longint unsigned m;
    m = (64'd1 << w) - 64'd1;
    if (n == 0) return 0;
    x = 1;
    y = 1;
    for (int i = 2; i <= n; i++) begin
      t = (x + y) & m;
      x = y;
      y = t;
    end
    return y & m;
  endfunction

  task automatic chk(input string tag,
                     input longint unsigned obs,
                     input longint unsigned exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_x(input string tag);
    checks++;
    assert (!$isunknown(out32) && !$isunknown(out8))
    else begin
      failures++;
      $error("FAIL %s observed=%h/%h expected=known", tag, out32, out8);
    end
  endtask

  // Advance one edge, update the model, then check both instances.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) k = 0;
    else k++;
    #1;
    chk({tag, "_w32"}, 64'(out32), fib_out(k, 32));
    chk({tag, "_w8"}, 64'(out8), fib_out(k, 8));
  endtask

  int unsigned hold;
  int unsigned run;
  logic [31:0] prev;

  initial begin
    checks = 0;
    failures = 0;
    k = 0;
    rst = 1'b1;

    // Reset held for two edges
    step("reset_e1");
    step("reset_e2");
    chk("reset_const", 64'(out32), 64'd0);

    // First ten values, sampled ahead of each edge
    rst = 1'b0;
    begin
      longint unsigned seq[10] = '{0, 1, 2, 3, 5, 8, 13, 21, 34, 55};
      for (int i = 0; i < 10; i++) begin
        chk("seq", 64'(out32), seq[i]);
        step("seq_edge");
      end
    end

    // Continue to the 32-bit boundary, catching 8-bit wrap on the way
    while (k < 46) begin
      prev = out32;
      step("run");
      if (k == 11) chk("w8_144", 64'(out8), 64'd144);
      if (k == 12) chk("w8_233", 64'(out8), 64'd233);
      if (k == 13) chk("w8_wrap", 64'(out8), 64'd121);
    end
    chk("f47", 64'(out32), 64'd2971215073);
    chk("f46_prev", 64'(prev), 64'd1836311903);
    step("wrap_e47");
    chk("wrap47", 64'(out32), 64'd512559680);
    step("wrap_e48");
    chk("wrap48", 64'(out32), 64'd3483774753);
    chk_x("wrap_known");

    // Reset after wrap, then run to 89 and reset mid-sequence
    rst = 1'b1;
    step("rst_after_wrap");
    chk("rst_after_wrap_zero", 64'(out32), 64'd0);
    rst = 1'b0;
    while (out32 != 32'd89 && k < 20) step("to89");
    chk("reach89", 64'(out32), 64'd89);
    rst = 1'b1;
    step("mid_rst");
    chk("mid_rst_zero", 64'(out32), 64'd0);
    rst = 1'b0;
    begin
      longint unsigned rs[4] = '{1, 2, 3, 5};
      for (int i = 0; i < 4; i++) begin
        step("restart");
        chk("restart_seq", 64'(out32), rs[i]);
      end
    end

    // Random reset bursts and run lengths
    for (int it = 0; it < 12; it++) begin
      hold = $urandom_range(3, 1);
      run = $urandom_range(120, 1);
      rst = 1'b1;
      for (int j = 0; j < int'(hold); j++) step("rnd_rst");
      rst = 1'b0;
      for (int j = 0; j < int'(run); j++) step("rnd_run");
      chk_x("rnd_known");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
